// File: rtl/lsu_lsq_issue_if.sv
// ---------------------------------------------------------------------------
// lsu_lsq_issue_if
// Bundles the dcache request/response channel and the writeback/ROB
// completion channel of the LSQ issue stage.
//   master : the issue stage. Drives the dcache request and the writeback.
//            Receives the dcache ready and the response.
//   slave  : the dcache / writeback side. This is the mirror image of master.
// Signal names keep the issue stage's point of view: an _o suffix means the
// issue stage drives the signal, and an _i suffix means it receives it.
// ---------------------------------------------------------------------------
interface lsu_lsq_issue_if #(
  parameter int PADDR_WIDTH   = 56,
  parameter int OPCODE_WIDTH  = 4,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int ECAUSE_WIDTH  = 4,
  parameter int XLEN          = 64
);
  logic                     dc_req_vld_o;
  logic                     dc_req_rdy_i;
  logic [PADDR_WIDTH-1:0]   dc_req_paddr_o;
  logic [OPCODE_WIDTH-1:0]  dc_req_opcode_o;
  logic                     dc_req_st_o;
  logic [XLEN-1:0]          dc_req_data_o;
  logic                     dc_resp_vld_i;
  logic                     dc_resp_replay_i;
  logic [XLEN-1:0]          dc_resp_data_i;
  logic                     wb_vld_o;
  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx_o;
  logic [XLEN-1:0]          wb_data_o;
  logic                     wb_exc_o;
  logic [ECAUSE_WIDTH-1:0]  wb_ecause_o;

  modport master (
    output dc_req_vld_o, dc_req_paddr_o, dc_req_opcode_o, dc_req_st_o, dc_req_data_o,
    input  dc_req_rdy_i,
    input  dc_resp_vld_i, dc_resp_replay_i, dc_resp_data_i,
    output wb_vld_o, wb_rob_idx_o, wb_data_o, wb_exc_o, wb_ecause_o
  );

  modport slave (
    input  dc_req_vld_o, dc_req_paddr_o, dc_req_opcode_o, dc_req_st_o, dc_req_data_o,
    output dc_req_rdy_i,
    output dc_resp_vld_i, dc_resp_replay_i, dc_resp_data_i,
    input  wb_vld_o, wb_rob_idx_o, wb_data_o, wb_exc_o, wb_ecause_o
  );
endinterface

// File: rtl/lsu_lsq_issue.sv
// ---------------------------------------------------------------------------
// lsu_lsq_issue
// Issue stage behind the LSQ entry array. Each cycle it picks the oldest
// ready entry, scanning from the queue head and wrapping around. It then
// sends that entry to the dcache and updates the entry through one-hot
// strobes. At most one dcache access is outstanding at any time. An entry
// that already carries an exception completes immediately, with no cache
// access.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   flush          synchronous pipeline flush (active-high)
//   lsq_head_i     index of the oldest LSQ entry
//   ent_*_i        per-entry status bits and flattened per-entry payloads
//   ent_exec_o     one-hot "issued" strobe back to the entry
//   ent_replay_o   one-hot "replay" strobe back to the entry
//   ent_succ_o     one-hot "completed" strobe back to the entry
//   bus            dcache request/response and writeback channels (master)
// ---------------------------------------------------------------------------
module lsu_lsq_issue #(
  parameter int LSQ_DEPTH     = 8,
  parameter int LSQ_PTR_WIDTH = 3,
  parameter int PADDR_WIDTH   = 56,
  parameter int OPCODE_WIDTH  = 4,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int ECAUSE_WIDTH  = 4,
  parameter int XLEN          = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [LSQ_PTR_WIDTH-1:0]           lsq_head_i,
  input  logic [LSQ_DEPTH-1:0]               ent_vld_i,
  input  logic [LSQ_DEPTH-1:0]               ent_awake_i,
  input  logic [LSQ_DEPTH-1:0]               ent_exec_i,
  input  logic [LSQ_DEPTH-1:0]               ent_succ_i,
  input  logic [LSQ_DEPTH-1:0]               ent_virt_i,
  input  logic [LSQ_DEPTH-1:0]               ent_exc_i,
  input  logic [LSQ_DEPTH-1:0]               ent_ls_i,
  input  logic [LSQ_DEPTH*PADDR_WIDTH-1:0]   ent_paddr_i,
  input  logic [LSQ_DEPTH*OPCODE_WIDTH-1:0]  ent_opcode_i,
  input  logic [LSQ_DEPTH*XLEN-1:0]          ent_data_i,
  input  logic [LSQ_DEPTH*ROB_IDX_WIDTH-1:0] ent_rob_idx_i,
  input  logic [LSQ_DEPTH*ECAUSE_WIDTH-1:0]  ent_ecause_i,
  output logic [LSQ_DEPTH-1:0]               ent_exec_o,
  output logic [LSQ_DEPTH-1:0]               ent_replay_o,
  output logic [LSQ_DEPTH-1:0]               ent_succ_o,
  lsu_lsq_issue_if.master                    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [LSQ_DEPTH-1:0] ONE_HOT_LSB = {{(LSQ_DEPTH-1){1'b0}}, 1'b1};

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [LSQ_PTR_WIDTH-1:0]   r_sel_idx;
  logic [LSQ_PTR_WIDTH-1:0]   w_sel_idx_nxt;

  logic [LSQ_DEPTH-1:0]       w_rdy;
  logic                       w_pick_vld;
  logic [LSQ_PTR_WIDTH-1:0]   w_pick_idx;
  logic [LSQ_PTR_WIDTH-1:0]   w_scan_idx;
  logic [LSQ_DEPTH-1:0]       w_pick_oh;
  logic [LSQ_DEPTH-1:0]       w_sel_oh;

  logic [PADDR_WIDTH-1:0]     w_paddr   [LSQ_DEPTH];
  logic [OPCODE_WIDTH-1:0]    w_opcode  [LSQ_DEPTH];
  logic [XLEN-1:0]            w_data    [LSQ_DEPTH];
  logic [ROB_IDX_WIDTH-1:0]   w_rob_idx [LSQ_DEPTH];
  logic [ECAUSE_WIDTH-1:0]    w_ecause  [LSQ_DEPTH];

  // Unpack the flattened per-entry payload buses into indexable arrays.
  for (genvar k = 0; k < LSQ_DEPTH; k++) begin : g_unpack
    assign w_paddr[k]   = ent_paddr_i[k*PADDR_WIDTH +: PADDR_WIDTH];
    assign w_opcode[k]  = ent_opcode_i[k*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign w_data[k]    = ent_data_i[k*XLEN +: XLEN];
    assign w_rob_idx[k] = ent_rob_idx_i[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
    assign w_ecause[k]  = ent_ecause_i[k*ECAUSE_WIDTH +: ECAUSE_WIDTH];
  end

  // An entry with an exception is issuable even while its tag is still
  // virtual, because it will never reach the cache.
  assign w_rdy = ent_vld_i & ent_awake_i & ~ent_exec_i & ~ent_succ_i
               & (ent_exc_i | ~ent_virt_i);

  // Scan from the farthest offset back toward the head. The last hit found
  // is the one nearest the head, which is the oldest ready entry. The pointer
  // arithmetic wraps naturally at LSQ_DEPTH.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan_idx = '0;
    for (int i = LSQ_DEPTH - 1; i >= 0; i--) begin
      w_scan_idx = lsq_head_i + LSQ_PTR_WIDTH'(i);
      if (w_rdy[w_scan_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_scan_idx;
      end
    end
  end

  assign w_pick_oh = ONE_HOT_LSB << w_pick_idx;
  assign w_sel_oh  = ONE_HOT_LSB << r_sel_idx;

  // State register. The selected index is held for the whole access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sel_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_idx <= w_sel_idx_nxt;
    end
  end

  // Next-state logic. Suppose a flush arrives while the dcache accepts the
  // request in the same cycle. A response is then owed, so the FSM goes to
  // DRAIN rather than IDLE. Likewise, a response that lands together with a
  // flush in WAIT settles the access, and the FSM returns straight to IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_idx_nxt = r_sel_idx;
    unique case (r_state)
      S_IDLE: begin
        if (!flush && w_pick_vld && !ent_exc_i[w_pick_idx]) begin
          w_state_nxt   = S_REQ;
          w_sel_idx_nxt = w_pick_idx;
        end
      end
      S_REQ: begin
        if (bus.dc_req_rdy_i) begin
          w_state_nxt = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.dc_resp_vld_i) begin
          w_state_nxt = S_IDLE;
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.dc_resp_vld_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. Every output depends only on the state, the selected
  // index, and the live inputs. All outputs are held at zero during reset.
  // The request channel stays up through a flush, so that an accept in that
  // cycle is still a clean handshake. Flush silences only the entry strobes
  // and writeback.
  always_comb begin
    ent_exec_o          = '0;
    ent_replay_o        = '0;
    ent_succ_o          = '0;
    bus.dc_req_vld_o    = 1'b0;
    bus.dc_req_paddr_o  = '0;
    bus.dc_req_opcode_o = '0;
    bus.dc_req_st_o     = 1'b0;
    bus.dc_req_data_o   = '0;
    bus.wb_vld_o        = 1'b0;
    bus.wb_rob_idx_o    = '0;
    bus.wb_data_o       = '0;
    bus.wb_exc_o        = 1'b0;
    bus.wb_ecause_o     = '0;
    if (rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (!flush && w_pick_vld) begin
            if (ent_exc_i[w_pick_idx]) begin
              ent_succ_o       = w_pick_oh;
              bus.wb_vld_o     = 1'b1;
              bus.wb_exc_o     = 1'b1;
              bus.wb_ecause_o  = w_ecause[w_pick_idx];
              bus.wb_rob_idx_o = w_rob_idx[w_pick_idx];
            end else begin
              ent_exec_o = w_pick_oh;
            end
          end
        end
        S_REQ: begin
          bus.dc_req_vld_o    = 1'b1;
          bus.dc_req_paddr_o  = w_paddr[r_sel_idx];
          bus.dc_req_opcode_o = w_opcode[r_sel_idx];
          bus.dc_req_st_o     = ent_ls_i[r_sel_idx];
          bus.dc_req_data_o   = w_data[r_sel_idx];
        end
        S_WAIT: begin
          if (!flush && bus.dc_resp_vld_i) begin
            if (bus.dc_resp_replay_i) begin
              ent_replay_o = w_sel_oh;
            end else begin
              ent_succ_o       = w_sel_oh;
              bus.wb_vld_o     = 1'b1;
              bus.wb_rob_idx_o = w_rob_idx[r_sel_idx];
              bus.wb_data_o    = ent_ls_i[r_sel_idx] ? '0 : bus.dc_resp_data_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_lsq_issue.sv
// ---------------------------------------------------------------------------
// tb_lsu_lsq_issue
// Directed bench for the LSQ issue stage. The bench plays two roles:
//   - the dcache, driven by hand in each step;
//   - a minimal LSQ that latches the exec, replay and succ strobes.
// Each writeback is checked against a queue of expected completions that is
// filled as the stimulus is driven.
// ---------------------------------------------------------------------------
module tb_lsu_lsq_issue;

  localparam int D  = 8;
  localparam int PW = 56;
  localparam int OW = 4;
  localparam int RW = 4;
  localparam int EW = 4;
  localparam int XL = 64;

  typedef struct {
    logic [RW-1:0] rob;
    logic [XL-1:0] data;
    logic          exc;
    logic [EW-1:0] ecause;
  } wb_t;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [2:0]      lsq_head_i;
  logic [D-1:0]    ent_vld_i, ent_awake_i, ent_exec_i, ent_succ_i;
  logic [D-1:0]    ent_virt_i, ent_exc_i, ent_ls_i;
  logic [D*PW-1:0] ent_paddr_i;
  logic [D*OW-1:0] ent_opcode_i;
  logic [D*XL-1:0] ent_data_i;
  logic [D*RW-1:0] ent_rob_idx_i;
  logic [D*EW-1:0] ent_ecause_i;
  logic [D-1:0]    ent_exec_o, ent_replay_o, ent_succ_o;

  int  passCount  = 0;
  int  totalCount = 0;
  int  failCount  = 0;
  wb_t sbQ[$];

  lsu_lsq_issue_if bus ();

  lsu_lsq_issue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .lsq_head_i    (lsq_head_i),
    .ent_vld_i     (ent_vld_i),
    .ent_awake_i   (ent_awake_i),
    .ent_exec_i    (ent_exec_i),
    .ent_succ_i    (ent_succ_i),
    .ent_virt_i    (ent_virt_i),
    .ent_exc_i     (ent_exc_i),
    .ent_ls_i      (ent_ls_i),
    .ent_paddr_i   (ent_paddr_i),
    .ent_opcode_i  (ent_opcode_i),
    .ent_data_i    (ent_data_i),
    .ent_rob_idx_i (ent_rob_idx_i),
    .ent_ecause_i  (ent_ecause_i),
    .ent_exec_o    (ent_exec_o),
    .ent_replay_o  (ent_replay_o),
    .ent_succ_o    (ent_succ_o),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] paddrOf(input int k);
    return 56'h00_1000_0000_0040 + PW'(k) * 56'h100;
  endfunction

  function automatic logic [OW-1:0] opcodeOf(input int k);
    return OW'(k + 9);
  endfunction

  function automatic logic [RW-1:0] robOf(input int k);
    return RW'(k + 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Make entry k issuable, with a payload derived from k.
  task automatic applyStimulus(input int k, input logic ls, input logic exc, input logic virt,
                               input logic [EW-1:0] ecause, input logic [XL-1:0] data);
    ent_vld_i[k]                   = 1'b1;
    ent_awake_i[k]                 = 1'b1;
    ent_exec_i[k]                  = 1'b0;
    ent_succ_i[k]                  = 1'b0;
    ent_virt_i[k]                  = virt;
    ent_exc_i[k]                   = exc;
    ent_ls_i[k]                    = ls;
    ent_paddr_i[k*PW +: PW]        = paddrOf(k);
    ent_opcode_i[k*OW +: OW]       = opcodeOf(k);
    ent_data_i[k*XL +: XL]         = data;
    ent_rob_idx_i[k*RW +: RW]      = robOf(k);
    ent_ecause_i[k*EW +: EW]       = ecause;
  endtask

  task automatic clearAll();
    lsq_head_i    = '0;
    ent_vld_i     = '0;
    ent_awake_i   = '0;
    ent_exec_i    = '0;
    ent_succ_i    = '0;
    ent_virt_i    = '0;
    ent_exc_i     = '0;
    ent_ls_i      = '0;
    ent_paddr_i   = '0;
    ent_opcode_i  = '0;
    ent_data_i    = '0;
    ent_rob_idx_i = '0;
    ent_ecause_i  = '0;
  endtask

  // Sample the settled outputs before the edge. Score any writeback against
  // the expected queue, then let the mini-LSQ absorb the strobes after the
  // edge.
  task automatic tick();
    logic [D-1:0] e, r, s;
    wb_t          x;
    #2;
    e = ent_exec_o;
    r = ent_replay_o;
    s = ent_succ_o;
    if (bus.wb_vld_o) begin
      if (sbQ.size() == 0) begin
        checkOutput("wb_unexpected", 64'(bus.wb_vld_o), 64'd0);
      end else begin
        x = sbQ.pop_front();
        checkOutput("wb_rob", 64'(bus.wb_rob_idx_o), 64'(x.rob));
        checkOutput("wb_data", bus.wb_data_o, x.data);
        checkOutput("wb_exc", 64'(bus.wb_exc_o), 64'(x.exc));
        checkOutput("wb_ecause", 64'(bus.wb_ecause_o), 64'(x.ecause));
      end
    end
    @(posedge clk);
    #1;
    ent_exec_i = (ent_exec_i | e) & ~r;
    ent_succ_i = ent_succ_i | s;
  endtask

  // Directed sequence.
  initial begin
    rst                  = 1'b0;
    flush                = 1'b0;
    bus.dc_req_rdy_i     = 1'b0;
    bus.dc_resp_vld_i    = 1'b0;
    bus.dc_resp_replay_i = 1'b0;
    bus.dc_resp_data_i   = '0;
    clearAll();
    applyStimulus(2, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    tick();
    tick();
    #1;
    checkOutput("rst_exec", 64'(ent_exec_o), 64'd0);
    checkOutput("rst_req_vld", 64'(bus.dc_req_vld_o), 64'd0);
    checkOutput("rst_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    tick();

    $display("[TB] basic load on entry 2");
    rst = 1'b1;
    bus.dc_req_rdy_i = 1'b1;
    #1;
    checkOutput("t1_exec", 64'(ent_exec_o), 64'h04);
    checkOutput("t1_req_idle", 64'(bus.dc_req_vld_o), 64'd0);
    tick();
    #1;
    checkOutput("t1_req_vld", 64'(bus.dc_req_vld_o), 64'd1);
    checkOutput("t1_paddr", 64'(bus.dc_req_paddr_o), 64'(paddrOf(2)));
    checkOutput("t1_opcode", 64'(bus.dc_req_opcode_o), 64'(opcodeOf(2)));
    checkOutput("t1_st", 64'(bus.dc_req_st_o), 64'd0);
    checkOutput("t1_exec_req", 64'(ent_exec_o), 64'd0);
    tick();
    #1;
    checkOutput("t1_wait_vld", 64'(bus.dc_req_vld_o), 64'd0);
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'hDEAD;
    sbQ.push_back('{robOf(2), 64'hDEAD, 1'b0, 4'd0});
    #1;
    checkOutput("t1_succ", 64'(ent_succ_o), 64'h04);
    checkOutput("t1_wb_vld", 64'(bus.wb_vld_o), 64'd1);
    tick();
    bus.dc_resp_vld_i = 1'b0;
    clearAll();

    $display("[TB] head wrap, entries 7 then 1");
    lsq_head_i = 3'd6;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    applyStimulus(7, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    #1;
    checkOutput("t2_exec7", 64'(ent_exec_o), 64'h80);
    tick();
    #1;
    checkOutput("t2_paddr7", 64'(bus.dc_req_paddr_o), 64'(paddrOf(7)));
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'h77;
    sbQ.push_back('{robOf(7), 64'h77, 1'b0, 4'd0});
    #1;
    checkOutput("t2_succ7", 64'(ent_succ_o), 64'h80);
    tick();
    bus.dc_resp_vld_i = 1'b0;
    #1;
    checkOutput("t2_exec1", 64'(ent_exec_o), 64'h02);
    tick();
    #1;
    checkOutput("t2_paddr1", 64'(bus.dc_req_paddr_o), 64'(paddrOf(1)));
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'h11;
    sbQ.push_back('{robOf(1), 64'h11, 1'b0, 4'd0});
    #1;
    checkOutput("t2_succ1", 64'(ent_succ_o), 64'h02);
    tick();
    bus.dc_resp_vld_i = 1'b0;
    clearAll();

    $display("[TB] exception entry 3");
    applyStimulus(3, 1'b0, 1'b1, 1'b1, 4'd5, 64'h0);
    sbQ.push_back('{robOf(3), 64'h0, 1'b1, 4'd5});
    #1;
    checkOutput("t3_succ", 64'(ent_succ_o), 64'h08);
    checkOutput("t3_exec", 64'(ent_exec_o), 64'd0);
    checkOutput("t3_req_vld", 64'(bus.dc_req_vld_o), 64'd0);
    checkOutput("t3_wb_exc", 64'(bus.wb_exc_o), 64'd1);
    checkOutput("t3_wb_ecause", 64'(bus.wb_ecause_o), 64'd5);
    tick();
    #1;
    checkOutput("t3_req_after", 64'(bus.dc_req_vld_o), 64'd0);
    checkOutput("t3_succ_after", 64'(ent_succ_o), 64'd0);
    clearAll();
    tick();

    $display("[TB] backpressure and replay on entry 4");
    bus.dc_req_rdy_i = 1'b0;
    applyStimulus(4, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    #1;
    checkOutput("t4_exec", 64'(ent_exec_o), 64'h10);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("t4_hold_vld", 64'(bus.dc_req_vld_o), 64'd1);
      checkOutput("t4_hold_paddr", 64'(bus.dc_req_paddr_o), 64'(paddrOf(4)));
      tick();
    end
    bus.dc_req_rdy_i = 1'b1;
    #1;
    checkOutput("t4_accept_vld", 64'(bus.dc_req_vld_o), 64'd1);
    tick();
    bus.dc_resp_vld_i    = 1'b1;
    bus.dc_resp_replay_i = 1'b1;
    bus.dc_resp_data_i   = 64'hBAD;
    #1;
    checkOutput("t4_replay", 64'(ent_replay_o), 64'h10);
    checkOutput("t4_succ", 64'(ent_succ_o), 64'd0);
    checkOutput("t4_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    tick();
    bus.dc_resp_vld_i    = 1'b0;
    bus.dc_resp_replay_i = 1'b0;
    #1;
    checkOutput("t4_repick", 64'(ent_exec_o), 64'h10);
    tick();
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'h44;
    sbQ.push_back('{robOf(4), 64'h44, 1'b0, 4'd0});
    tick();
    bus.dc_resp_vld_i = 1'b0;
    clearAll();

    $display("[TB] flush during wait on entry 0");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    #1;
    checkOutput("t5_exec", 64'(ent_exec_o), 64'h01);
    tick();
    tick();
    flush = 1'b1;
    #1;
    checkOutput("t5_flush_succ", 64'(ent_succ_o), 64'd0);
    checkOutput("t5_flush_wb", 64'(bus.wb_vld_o), 64'd0);
    tick();
    flush = 1'b0;
    clearAll();
    #1;
    checkOutput("t5_drain_req", 64'(bus.dc_req_vld_o), 64'd0);
    tick();
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'h55;
    #1;
    checkOutput("t5_drain_wb", 64'(bus.wb_vld_o), 64'd0);
    checkOutput("t5_drain_succ", 64'(ent_succ_o), 64'd0);
    tick();
    bus.dc_resp_vld_i = 1'b0;
    applyStimulus(6, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    #1;
    checkOutput("t5_idle_pick", 64'(ent_exec_o), 64'h40);
    clearAll();
    tick();

    $display("[TB] store on entry 5");
    applyStimulus(5, 1'b1, 1'b0, 1'b0, 4'd0, 64'h1234);
    #1;
    checkOutput("t6_exec", 64'(ent_exec_o), 64'h20);
    tick();
    #1;
    checkOutput("t6_st", 64'(bus.dc_req_st_o), 64'd1);
    checkOutput("t6_data", bus.dc_req_data_o, 64'h1234);
    tick();
    bus.dc_resp_vld_i  = 1'b1;
    bus.dc_resp_data_i = 64'hFFFF;
    sbQ.push_back('{robOf(5), 64'h0, 1'b0, 4'd0});
    #1;
    checkOutput("t6_wb_vld", 64'(bus.wb_vld_o), 64'd1);
    checkOutput("t6_wb_data", bus.wb_data_o, 64'h0);
    tick();
    bus.dc_resp_vld_i = 1'b0;
    clearAll();
    tick();

    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
